// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the character LCD controller.
//   - HD44780 command constants (8-bit interface)
//   - controller and bus-transaction state enums
//   - helpers: DDRAM row address command, display-control word, init command table
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_CTRL     = 8'h08;
  localparam logic [7:0] DISP_ON       = 8'h04;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] SET_DDRAM     = 8'h80;

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_IDLE, ST_CTRL, ST_ROWADDR, ST_CHAR, ST_DONE
  } lcd_state_e;

  typedef enum logic [1:0] {
    XF_IDLE, XF_SETUP, XF_PULSE, XF_WAIT
  } xfer_phase_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Rows 2/3 of a 4-line module continue rows 0/1 at offset COLS.
  function automatic logic [7:0] row_addr_cmd(input int row, input int cols);
    logic [7:0] base;
    case (row)
      0:       base = 8'h00;
      1:       base = 8'h40;
      2:       base = 8'(cols);
      default: base = 8'(8'h40 + cols);
    endcase
    return SET_DDRAM | base;
  endfunction

  function automatic logic [7:0] disp_ctrl_cmd(input logic cursor, input logic blink);
    return DISP_CTRL | DISP_ON | {6'b0, cursor, blink};
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET_8B2L;
      2'd1:    return DISP_CTRL | DISP_ON;
      2'd2:    return CLEAR;
      default: return ENTRY_INC;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// lcd_bus_xfer: one LCD write transaction with bus timing.
//   start      - load rs/data and begin a transaction (setup cycle follows)
//   rs, data   - register select and data byte for the write
//   wait_long  - use CLR_WAIT_CYC instead of CMD_WAIT_CYC after E falls
//   E, RS, DB  - LCD pins; RS/DB held from setup through the end of the wait
//   xfer_done  - high in the last wait cycle; a start in that cycle chains
//                the next write with no idle gap
module lcd_bus_xfer
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int CW           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       wait_long,
  output logic       E,
  output logic       RS,
  output logic [7:0] DB,
  output logic       xfer_done
);

  xfer_phase_e   phase;
  logic [CW-1:0] cnt;
  logic          long_q;
  logic [CW-1:0] wait_last;

  assign wait_last = long_q ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
  assign xfer_done = (phase == XF_WAIT) && (cnt == wait_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase  <= XF_IDLE;
      cnt    <= '0;
      long_q <= 1'b0;
      E      <= 1'b0;
      RS     <= 1'b0;
      DB     <= 8'h00;
    end else if (start) begin
      phase  <= XF_SETUP;
      cnt    <= '0;
      long_q <= wait_long;
      E      <= 1'b0;
      RS     <= rs;
      DB     <= data;
    end else begin
      case (phase)
        XF_SETUP: begin
          phase <= XF_PULSE;
          E     <= 1'b1;
          cnt   <= '0;
        end
        XF_PULSE: begin
          if (cnt == CW'(E_PULSE_CYC - 1)) begin
            phase <= XF_WAIT;
            E     <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XF_WAIT: begin
          if (xfer_done) phase <= XF_IDLE;
          else           cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: HD44780-class character LCD controller, 8-bit write-only bus.
//   clk, reset          - clock, asynchronous active-low reset
//   ASCII               - ROWS*COLS text, row-major, index 0 = row 0 col 0
//   update_req          - level refresh request, sampled in IDLE only
//   cursor_on, blink_on - display-control options, sampled with the request
//   busy, done          - busy from init/accept until done; done is one cycle
//   E, RS, RW, DB       - LCD pins (RW tied low)
// Sequencing only; bus timing lives in lcd_bus_xfer.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int ROWS         = 2,
  parameter int COLS         = 16,
  parameter int POWERUP_CYC  = 750000,
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [0:ROWS*COLS-1][7:0]  ASCII,
  input  logic                       update_req,
  input  logic                       cursor_on,
  input  logic                       blink_on,
  output logic                       busy,
  output logic                       done,
  output logic                       E,
  output logic                       RS,
  output logic                       RW,
  output logic [7:0]                 DB
);

  localparam int N    = ROWS * COLS;
  localparam int MAXW = max2(max2(POWERUP_CYC, E_PULSE_CYC), max2(CMD_WAIT_CYC, CLR_WAIT_CYC));
  localparam int CW   = $clog2(MAXW) + 1;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int RWD  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;

  generate
    if (!(ROWS == 1 || ROWS == 2 || ROWS == 4)) begin : g_bad_rows
      $error("lcd_text_ctrl: ROWS must be 1, 2 or 4");
    end
    if (COLS < 1 || (ROWS <= 2 && COLS > 40) || (ROWS == 4 && COLS > 20)) begin : g_bad_cols
      $error("lcd_text_ctrl: COLS out of range for ROWS");
    end
  endgenerate

  lcd_state_e             state, nstate;
  logic [CW-1:0]          pu_cnt;
  logic [1:0]             init_idx;
  logic [RWD-1:0]         row_q;
  logic [CLW-1:0]         col_q;
  logic [IW-1:0]          idx_q, nxt_idx;
  logic [0:N-1][7:0]      text_q;

  logic       accept, pu_last, last_col, last_row;
  logic       x_start, x_rs, x_wait_long, xfer_done;
  logic [7:0] x_data;

  assign accept   = (state == ST_IDLE) && (update_req || (AUTO_REFRESH != 0));
  assign pu_last  = (pu_cnt == CW'(POWERUP_CYC - 1));
  assign last_col = (col_q == CLW'(COLS - 1));
  assign last_row = (row_q == RWD'(ROWS - 1));
  assign nxt_idx  = idx_q + 1'b1;
  assign RW       = 1'b0;

  // Only the clear command needs the long post-write wait.
  assign x_wait_long = !x_rs && (x_data == CLEAR);

  lcd_bus_xfer #(
    .E_PULSE_CYC (E_PULSE_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC),
    .CW          (CW)
  ) u_xfer (
    .clk      (clk),
    .reset    (reset),
    .start    (x_start),
    .rs       (x_rs),
    .data     (x_data),
    .wait_long(x_wait_long),
    .E        (E),
    .RS       (RS),
    .DB       (DB),
    .xfer_done(xfer_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_POWERUP;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_POWERUP: if (pu_last) nstate = ST_INIT;
      ST_INIT:    if (xfer_done && init_idx == 2'd3) nstate = ST_IDLE;
      ST_IDLE:    if (accept) nstate = ST_CTRL;
      ST_CTRL:    if (xfer_done) nstate = ST_ROWADDR;
      ST_ROWADDR: if (xfer_done) nstate = ST_CHAR;
      ST_CHAR:    if (xfer_done && last_col) nstate = last_row ? ST_DONE : ST_ROWADDR;
      ST_DONE:    nstate = ST_IDLE;
      default:    nstate = ST_POWERUP;
    endcase
  end

  // Each write is launched in the cycle the previous one finishes, so the
  // launching state supplies the *next* word. The control word is built from
  // the live cursor/blink inputs in the accepting cycle; the bus unit latches
  // it at the same edge that snapshots the text.
  always_comb begin
    x_start = 1'b0;
    x_rs    = 1'b0;
    x_data  = 8'h00;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      ST_POWERUP: if (pu_last) begin
        x_start = 1'b1;
        x_data  = init_cmd(2'd0);
      end
      ST_INIT: if (xfer_done && init_idx != 2'd3) begin
        x_start = 1'b1;
        x_data  = init_cmd(init_idx + 2'd1);
      end
      ST_IDLE: begin
        busy = accept;
        if (accept) begin
          x_start = 1'b1;
          x_data  = disp_ctrl_cmd(cursor_on, blink_on);
        end
      end
      ST_CTRL: if (xfer_done) begin
        x_start = 1'b1;
        x_data  = row_addr_cmd(0, COLS);
      end
      ST_ROWADDR: if (xfer_done) begin
        x_start = 1'b1;
        x_rs    = 1'b1;
        x_data  = text_q[idx_q];
      end
      ST_CHAR: if (xfer_done) begin
        if (!last_col) begin
          x_start = 1'b1;
          x_rs    = 1'b1;
          x_data  = text_q[nxt_idx];
        end else if (!last_row) begin
          x_start = 1'b1;
          x_data  = row_addr_cmd(int'(row_q) + 1, COLS);
        end
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // idx_q runs row-major across the whole buffer; row/col only mark row ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pu_cnt   <= '0;
      init_idx <= '0;
      row_q    <= '0;
      col_q    <= '0;
      idx_q    <= '0;
      text_q   <= '0;
    end else begin
      if (state == ST_POWERUP) pu_cnt <= pu_cnt + 1'b1;
      if (state == ST_INIT && xfer_done) init_idx <= init_idx + 2'd1;
      if (accept) begin
        text_q <= ASCII;
        row_q  <= '0;
        col_q  <= '0;
        idx_q  <= '0;
      end
      if (state == ST_CHAR && xfer_done) begin
        idx_q <= nxt_idx;
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb_lcd_text_ctrl: directed bench for lcd_text_ctrl.
//   dut  : 2x4, manual refresh, short timing
//   dut4 : 4x20, auto refresh, same timing
module tb_lcd_text_ctrl;

  logic clk, rst, rst4;
  logic req, cur, blk;
  logic [0:7][7:0]  ascii;
  logic [0:79][7:0] ascii4;
  logic busy, done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;
  logic busy4, done4, e4, rs4, rw4;
  logic [7:0] db4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic rs; logic [7:0] db; int hi; int lo; int fall; } wr_t;
  wr_t        wq[$];
  int         done_q[$];
  int         busy_fall;
  logic [8:0] q4[$];
  int         done4_q[$];
  int         last_low4 = -1;
  logic [8:0] expq[$];

  lcd_text_ctrl #(.ROWS(2), .COLS(4), .POWERUP_CYC(20), .E_PULSE_CYC(3),
                  .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(12), .AUTO_REFRESH(0)) dut (
    .clk(clk), .reset(rst), .ASCII(ascii), .update_req(req), .cursor_on(cur),
    .blink_on(blk), .busy(busy), .done(done), .E(lcd_e), .RS(lcd_rs), .RW(lcd_rw), .DB(lcd_db));

  lcd_text_ctrl #(.ROWS(4), .COLS(20), .POWERUP_CYC(20), .E_PULSE_CYC(3),
                  .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(12), .AUTO_REFRESH(1)) dut4 (
    .clk(clk), .reset(rst4), .ASCII(ascii4), .update_req(1'b0), .cursor_on(1'b0),
    .blink_on(1'b0), .busy(busy4), .done(done4), .E(e4), .RS(rs4), .RW(rw4), .DB(db4));

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #1000000; $display("FAIL watchdog expired"); $fatal(1, "watchdog"); end

  // Bus monitor for dut: one record per E falling edge.
  initial begin
    int hi_n, lo_n, lo_save;
    logic e_prev, b_prev;
    hi_n = 0; lo_n = 0; lo_save = 0; e_prev = 0; b_prev = 1;
    forever begin
      @(negedge clk);
      if (lcd_e) begin
        if (!e_prev) begin lo_save = lo_n; hi_n = 0; end
        hi_n++;
        lo_n = 0;
      end else begin
        if (e_prev) wq.push_back('{lcd_rs, lcd_db, hi_n, lo_save, cyc});
        lo_n++;
      end
      if (b_prev && !busy) busy_fall = cyc;
      if (done) done_q.push_back(cyc);
      e_prev = lcd_e;
      b_prev = busy;
    end
  end

  // Bus monitor for dut4.
  initial begin
    int low_n;
    logic e_prev;
    low_n = 0; e_prev = 0;
    forever begin
      @(negedge clk);
      if (!e4 && e_prev) q4.push_back({rs4, db4});
      if (done4) done4_q.push_back(cyc);
      if (busy4) begin
        if (low_n > 0) last_low4 = low_n;
        low_n = 0;
      end else low_n++;
      e_prev = e4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ascii(input string s);
    for (int i = 0; i < 8; i++) ascii[i] = s[i];
  endtask

  task automatic build_exp(input string s, input logic c, input logic b);
    expq.delete();
    expq.push_back({1'b0, 8'h0C | {6'b0, c, b}});
    expq.push_back({1'b0, 8'h80});
    for (int i = 0; i < 4; i++) expq.push_back({1'b1, s[i]});
    expq.push_back({1'b0, 8'hC0});
    for (int i = 4; i < 8; i++) expq.push_back({1'b1, s[i]});
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_nwr"}, wq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      chk({tag, "_wr"}, {wq[i].rs, wq[i].db}, expq[i]);
      chk({tag, "_ehi"}, wq[i].hi, 3);
    end
  endtask

  task automatic check_init(input int r);
    logic [7:0] initv [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    for (int k = 0; k < 400; k++) begin tick(); if (!busy) break; end
    chk("init_busy_fall", busy, 0);
    chk("init_nwr", wq.size(), 4);
    chk("pu_delay", wq[0].fall - wq[0].hi - r, 21);
    for (int i = 0; i < 4; i++) begin
      chk("init_cmd", {wq[i].rs, wq[i].db}, {1'b0, initv[i]});
      chk("init_ehi", wq[i].hi, 3);
    end
    chk("gap_38", wq[1].lo, 6);
    chk("gap_0c", wq[2].lo, 6);
    chk("gap_01", wq[3].lo, 13);
    chk("init_busy_time", busy_fall - wq[3].fall, 5);
    chk("init_no_done", done_q.size(), 0);
  endtask

  task automatic wait_done(input int n0, output logic bad);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done_q.size() > n0) break;
      if (!busy) bad = 1;
    end
    chk("done_seen", done_q.size(), n0 + 1);
  endtask

  initial begin
    int r, a, n;
    logic bad;
    rst = 0; rst4 = 0; req = 0; cur = 0; blk = 0;
    set_ascii("ABCDEFGH");
    for (int i = 0; i < 80; i++) ascii4[i] = 8'(8'h20 + i);
    repeat (3) tick();
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_db", lcd_db, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);

    rst4 = 1;
    wq.delete(); done_q.delete(); r = cyc; rst = 1;
    check_init(r);

    // Refresh with text change right after acceptance.
    wq.delete(); done_q.delete();
    cur = 1; blk = 0; req = 1;
    tick(); a = cyc;
    chk("acc_busy", busy, 1);
    req = 0; set_ascii("ZZZZZZZZ");
    wait_done(0, bad);
    chk("ref_latency", done_q[0] - a, 99);
    chk("ref_busy_hold", bad, 0);
    build_exp("ABCDEFGH", 1'b1, 1'b0);
    check_seq("ref1");
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);

    // Z text, blink only; a request pulse mid-refresh is dropped.
    wq.delete(); done_q.delete();
    cur = 0; blk = 1; req = 1;
    tick(); req = 0;
    repeat (30) tick();
    req = 1; tick(); req = 0;
    wait_done(0, bad);
    repeat (120) tick();
    chk("ignored_req_done", done_q.size(), 1);
    build_exp("ZZZZZZZZ", 1'b0, 1'b1);
    check_seq("ref2");

    // Held request: back-to-back refreshes.
    wq.delete(); done_q.delete();
    req = 1;
    for (int k = 0; k < 400; k++) begin tick(); if (done_q.size() >= 2) break; end
    req = 0;
    chk("held_done2", done_q.size(), 2);
    chk("held_gap", done_q[1] - done_q[0], 101);
    repeat (150) tick();
    chk("held_stop", done_q.size(), 2);
    chk("held_nwr", wq.size(), 22);

    // Reset in the middle of a character write with E high.
    wq.delete(); done_q.delete();
    req = 1; tick(); req = 0;
    for (int k = 0; k < 200; k++) begin tick(); if (lcd_e && lcd_rs) break; end
    chk("midchar_found", lcd_e & lcd_rs, 1);
    rst = 0; #1;
    chk("async_e", lcd_e, 0);
    chk("async_busy", busy, 1);
    chk("async_done", done, 0);
    repeat (2) tick();
    wq.delete(); done_q.delete(); r = cyc; rst = 1;
    check_init(r);

    // 4x20 auto refresh.
    n = done4_q.size();
    for (int k = 0; k < 2000; k++) begin tick(); if (done4_q.size() > n) break; end
    chk("auto_done1", done4_q.size(), n + 1);
    q4.delete(); n = done4_q.size();
    for (int k = 0; k < 2000; k++) begin tick(); if (done4_q.size() > n) break; end
    chk("auto_done2", done4_q.size(), n + 1);
    chk("auto_period", done4_q[n] - done4_q[n-1], 767);
    chk("auto_nwr", q4.size(), 85);
    chk("auto_ctrl", q4[0], {1'b0, 8'h0C});
    chk("auto_row0", q4[1], {1'b0, 8'h80});
    chk("auto_row1", q4[22], {1'b0, 8'hC0});
    chk("auto_row2", q4[43], {1'b0, 8'h94});
    chk("auto_row3", q4[64], {1'b0, 8'hD4});
    chk("auto_char40", q4[44], {1'b1, 8'h48});
    chk("auto_busy_low", last_low4, 1);
    chk("auto_rw", rw4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_text_ctrl.md
Name: lcd_text_ctrl

Overview:
- Parametrised HD44780-class character LCD controller; successor to the fixed 2x16 free-running LCD writer.
- Runs the power-up wait and init sequence with real bus timing (setup, E pulse width, per-command wait, long clear wait). After init it refreshes an ROWS x COLS text buffer on request through a busy/done handshake, or continuously in auto mode.
- Sits between the application text source and the LCD pins. Write-only bus, 8-bit mode.

Parameters:
- ROWS, 2, display lines; legal values 1, 2, 4; elaboration error otherwise.
- COLS, 16, characters per line; ≤40 if ROWS≤2, ≤20 if ROWS=4.
- POWERUP_CYC, 750000, clocks to wait after reset before the first command (15 ms at 50 MHz).
- E_PULSE_CYC, 25, clocks E is held high per write (≥450 ns).
- CMD_WAIT_CYC, 2500, clocks after E falls before the next write (50 us).
- CLR_WAIT_CYC, 82000, post-write wait for the clear command 0x01 (1.64 ms).
- AUTO_REFRESH, 0, 1 = restart the refresh immediately after each done, without update_req.

Ports:
- clk  in  1  master 50 MHz clock
- reset  in  1  asynchronous active-low reset
- ASCII  in  [0:ROWS*COLS-1][7:0]  text, row-major; index 0 = row 0 col 0
- update_req  in  1  level request for a refresh; sampled only in IDLE
- cursor_on  in  1  cursor enable, sampled with the request
- blink_on  in  1  blink enable, sampled with the request
- busy  out  1  high from the start of init, or from request acceptance, until done
- done  out  1  one-cycle pulse when a refresh completes
- E  out  1  LCD enable; data latched on the falling edge
- RS  out  1  0 = command, 1 = data
- RW  out  1  tied 0 (write only)
- DB  out  8  LCD data bus

Behaviour:
- Reset (asynchronous, immediate): E=0, RS=0, RW=0, DB=0, busy=1, done=0; state=POWERUP; all counters 0. Reset mid-transfer aborts the transfer and restarts the full power-up sequence.
- Bus write (one transaction): cycle 0 drives RS/DB with E=0 (setup). Cycles 1..E_PULSE_CYC drive E=1. E then falls, and RS/DB are held through the wait (CMD_WAIT_CYC, or CLR_WAIT_CYC for 0x01). Total = 1+E_PULSE_CYC+wait cycles. The next write's setup cycle follows immediately.
- States: POWERUP → INIT → IDLE → CTRL → ROWADDR → CHAR → (ROWADDR | DONE) → IDLE.
- POWERUP: count POWERUP_CYC cycles; outputs stay at their reset values.
- INIT: writes 0x38, 0x0C, 0x01 (long wait), 0x06 in that order. Then go to IDLE with busy=0. No done pulse after init.
- IDLE: if update_req=1 or AUTO_REFRESH=1, then in the same cycle:
  - snapshot ASCII into the internal buffer, and cursor_on/blink_on into registers;
  - set busy=1; go to CTRL.
  Changes to ASCII after acceptance do not affect the refresh in progress.
- CTRL: one write of 0x0C | cursor<<1 | blink.
- ROWADDR: one command write of 0x80 | base[row]. Bases: row0 0x00, row1 0x40, row2 COLS, row3 0x40+COLS. The address is issued once per row, not once per character.
- CHAR: COLS data writes (RS=1) of buffer[row*COLS+col]; col 0..COLS-1. After the last column, increment row and go to ROWADDR. After the last row, go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE. With AUTO_REFRESH=1, busy drops for that one cycle only and the next refresh is accepted on the following cycle.
- update_req held high → back-to-back refreshes. update_req while busy is ignored (not queued).
- Refresh length = 1 control write + ROWS address writes + ROWS*COLS data writes, each 1+E_PULSE_CYC+CMD_WAIT_CYC cycles, plus 1 DONE cycle.
- Counter width: $clog2(max of all wait params)+1. Char index width: $clog2(ROWS*COLS).

Decomposition:
- Package lcd_pkg: command constants (FUNC_SET_8B2L=0x38, DISP_CTRL=0x08, CLEAR=0x01, ENTRY_INC=0x06, SET_DDRAM=0x80), row base address function, controller state enum.
- Sub-module lcd_bus_xfer: one write transaction. Inputs start, rs, data[7:0], wait_long. Outputs E, RS, DB, xfer_done. Owns the timing counter. The top level is sequencing only.

Test Plan (POWERUP_CYC=20, E_PULSE_CYC=3, CMD_WAIT_CYC=5, CLR_WAIT_CYC=12, ROWS=2, COLS=4):
- Release reset → E stays 0 for 20 cycles; writes 0x38, 0x0C, 0x01, 0x06 with RS=0. Each E-high lasts exactly 3 cycles. The gap after 0x01 is 12 cycles, the others 5. busy falls after the 0x06 wait; no done pulse.
- Request with ASCII="ABCDEFGH", cursor_on=1, blink_on=0 → captured sequence 0x0E, 0x80, 'A','B','C','D', 0xC0, 'E','F','G','H'. RS=0 on commands, 1 on data. done pulses once, 99 cycles after acceptance (11 writes × 9 cycles). busy is high throughout.
- Change ASCII to "ZZZZZZZZ" one cycle after acceptance → the LCD still receives "ABCDEFGH". The next request sends Z's.
- Pulse update_req while busy → ignored; exactly one done. Hold update_req high → two consecutive refreshes, done twice.
- Assert reset mid-CHAR with E=1 → E=0 asynchronously, busy=1. After release, the full 20-cycle power-up and init repeat.
- ROWS=4, COLS=20, AUTO_REFRESH=1 → row addresses 0x80, 0xC0, 0x94, 0xD4. Refreshes repeat with no update_req; busy low for one cycle between them.
